pano_uart_rx: RTL

//  Receive side of the bring-up debug UART (8N1, LSB first, idle high). Samples the async rxd pin in
//  the osc_clk domain with 16x oversampling and delivers bytes over a valid/ready stream.

---
 rtl/pano_uart_pkg.sv | 21 ++
 rtl/pano_uart_tick_gen.sv | 27 ++
 rtl/pano_uart_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pano_uart_pkg.sv
// pano_uart_pkg: shared constants, FSM state type and parity helper
// for the bring-up debug UART receiver and transmitter.
package pano_uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_SAMPLE = 8;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pano_uart_tick_gen.sv
// pano_uart_tick_gen: free-running divider, one-cycle tick every CLK_DIV clocks.
// Ports: osc_clk, osc_reset (sync, active-high) in; tick out.
module pano_uart_tick_gen #(
  parameter int CLK_DIV = 54
) (
  input  logic osc_clk,
  input  logic osc_reset,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge osc_clk) begin
    if (osc_reset)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/pano_uart_rx.sv
// pano_uart_rx: 8N1 UART receiver, 16x oversampled, valid/ready byte output.
// Ports: osc_clk, osc_reset, rxd, rx_ready in; rx_data, rx_valid, frame_err, overrun out.
// Optional even parity bit when PANO_UART_RX_PARITY_EN is defined.
module pano_uart_rx
  import pano_uart_pkg::*;
#(
  parameter int CLK_DIV     = 54,
  parameter int SYNC_STAGES = 2
) (
  input  logic       osc_clk,
  input  logic       osc_reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [3:0] SUB_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST = 4'(UART_MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic                   w_tick;
  logic                   w_rxd;
  logic                   w_par_bad;
  logic [SYNC_STAGES-1:0] r_sync;
  uart_rx_state_t         r_state;
  logic [3:0]             r_sub;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_done;
  logic                   r_ferr;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ovr;

  pano_uart_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .osc_clk  (osc_clk),
    .osc_reset(osc_reset),
    .tick     (w_tick)
  );

  always_ff @(posedge osc_clk) begin
    if (osc_reset)
      r_sync <= '1;
    else
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end

  assign w_rxd = r_sync[SYNC_STAGES-1];

`ifdef PANO_UART_RX_PARITY_EN
  logic r_par_err;

  always_ff @(posedge osc_clk) begin
    if (osc_reset)
      r_par_err <= 1'b0;
    else if (w_tick && r_state == PARITY && r_sub == SUB_LAST)
      r_par_err <= w_rxd ^ even_par(r_shift);
  end

  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      r_state <= IDLE;
      r_sub   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          IDLE: begin
            if (!w_rxd) begin
              r_state <= START;
              r_sub   <= '0;
            end
          end
          START: begin
            if (r_sub == MID_LAST) begin
              // High at mid start bit: a glitch, not a frame.
              if (w_rxd) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_sub   <= '0;
                r_bit   <= '0;
              end
            end else begin
              r_sub <= r_sub + 1'b1;
            end
          end
          DATA: begin
            if (r_sub == SUB_LAST) begin
              r_sub   <= '0;
              r_shift <= {w_rxd, r_shift[7:1]};
              if (r_bit == BIT_LAST)
`ifdef PANO_UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              else
                r_bit <= r_bit + 1'b1;
            end else begin
              r_sub <= r_sub + 1'b1;
            end
          end
`ifdef PANO_UART_RX_PARITY_EN
          PARITY: begin
            if (r_sub == SUB_LAST) begin
              r_sub   <= '0;
              r_state <= STOP;
            end else begin
              r_sub <= r_sub + 1'b1;
            end
          end
`endif
          STOP: begin
            if (r_sub == SUB_LAST) begin
              // Leave at mid stop bit so a back-to-back start edge is seen.
              r_state <= IDLE;
              r_sub   <= '0;
              if (w_rxd && !w_par_bad)
                r_done <= 1'b1;
              else
                r_ferr <= 1'b1;
            end else begin
              r_sub <= r_sub + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_done) begin
        // Load when empty or when the held byte leaves this cycle.
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
